// File: rtl/meissa_pkg.sv
// Shared state encodings, array mode codes and counter widths for the meissa controller.
package meissa_pkg;

    localparam int CNT_W     = 4;
    localparam int JOB_CNT_W = 8;
    localparam int MODE_W    = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_PROC_LOAD = 3'd2,
        ST_OUT_PROC1 = 3'd3,
        ST_OUT_PROC2 = 3'd4,
        ST_OUT       = 3'd5,
        ST_RESULT    = 3'd6
    } state_t;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_INIT      = 3'b000;
    localparam mode_t MODE_LOAD      = 3'b001;
    localparam mode_t MODE_PROC_LOAD = 3'b010;
    localparam mode_t MODE_OUT_PROC1 = 3'b011;
    localparam mode_t MODE_OUT_PROC2 = 3'b100;
    localparam mode_t MODE_OUT       = 3'b101;

    function automatic mode_t mode_of(input state_t s);
        case (s)
            ST_LOAD:      return MODE_LOAD;
            ST_PROC_LOAD: return MODE_PROC_LOAD;
            ST_OUT_PROC1: return MODE_OUT_PROC1;
            ST_OUT_PROC2: return MODE_OUT_PROC2;
            ST_OUT:       return MODE_OUT;
            default:      return MODE_INIT;
        endcase
    endfunction

endpackage

// File: rtl/meissa_controller.sv
// Sequences one 2x2 matmul job through the systolic array modes, waits for the
// array result (with timeout) and hands it out over a valid/ready handshake.
module meissa_controller
    import meissa_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int MATRIX_SIZE  = 4,
    parameter int STAGE_CYCLES = 1,
    parameter int TIMEOUT      = 15
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [MATRIX_SIZE*DATA_WIDTH-1:0]   in_A,
    input  logic [MATRIX_SIZE*DATA_WIDTH-1:0]   in_B,
    output logic [MODE_W-1:0]                   mode,
    output logic [MATRIX_SIZE*DATA_WIDTH-1:0]   A,
    output logic [MATRIX_SIZE*DATA_WIDTH-1:0]   B,
    input  logic [2*MATRIX_SIZE*DATA_WIDTH-1:0] array_product,
    input  logic                                array_done,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [2*MATRIX_SIZE*DATA_WIDTH-1:0] out_product,
    output logic                                out_error,
    output logic                                busy,
    output logic [JOB_CNT_W-1:0]                job_count
);

    localparam int OP_W  = MATRIX_SIZE * DATA_WIDTH;
    localparam int RES_W = 2 * OP_W;
    localparam logic [CNT_W-1:0] STAGE_LAST   = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    mode_t                mode_q, mode_d;
    logic [OP_W-1:0]      a_q, a_d, b_q, b_d;
    logic [RES_W-1:0]     prod_q, prod_d;
    logic                 err_q, err_d;
    logic [JOB_CNT_W-1:0] jobs_q, jobs_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        err_d   = err_q;
        jobs_d  = jobs_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = in_A;
                    b_d     = in_B;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD:      if (cnt_q == STAGE_LAST) state_d = ST_PROC_LOAD;
            ST_PROC_LOAD: if (cnt_q == STAGE_LAST) state_d = ST_OUT_PROC1;
            ST_OUT_PROC1: if (cnt_q == STAGE_LAST) state_d = ST_OUT_PROC2;
            ST_OUT_PROC2: if (cnt_q == STAGE_LAST) state_d = ST_OUT;
            ST_OUT: begin
                // A result arriving on the last allowed cycle wins over the timeout.
                if (array_done) begin
                    prod_d  = array_product;
                    err_d   = 1'b0;
                    state_d = ST_RESULT;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (out_ready) begin
                    jobs_d  = jobs_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The single stage/timeout counter restarts on every state change.
        if (state_d != state_q || state_q == ST_IDLE || state_q == ST_RESULT) begin
            cnt_d = '0;
        end

        mode_d = mode_of(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_INIT;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
            jobs_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
            jobs_q  <= jobs_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign out_valid   = (state_q == ST_RESULT);
    assign mode        = mode_q;
    assign A           = a_q;
    assign B           = b_q;
    assign out_product = prod_q;
    assign out_error   = err_q;
    assign job_count   = jobs_q;

endmodule

// File: tb/tb_meissa_controller.sv
// Directed bench for meissa_controller: one instance with single-cycle stages,
// one with three-cycle stages for dwell and job counter wrap.
module tb_meissa_controller;

    localparam logic [63:0] P1 = 64'h0000_002E_0000_0022;
    localparam logic [63:0] P2 = 64'h0032_002B_0016_0013;

    logic        clk;
    logic        rst;
    logic        in_valid, out_ready, array_done;
    logic [31:0] in_A, in_B;
    logic [63:0] array_product;

    logic        in_ready, out_valid, out_error, busy;
    logic [2:0]  mode;
    logic [31:0] A, B;
    logic [63:0] out_product;
    logic [7:0]  job_count;

    logic        in_valid3, out_ready3, array_done3;
    logic        in_ready3, out_valid3, out_error3, busy3;
    logic [2:0]  mode3;
    logic [31:0] A3, B3;
    logic [63:0] out_product3;
    logic [7:0]  job_count3;

    int vec_cnt = 0;
    int err_cnt = 0;

    meissa_controller #(.DATA_WIDTH(8), .MATRIX_SIZE(4), .STAGE_CYCLES(1), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_A(in_A), .in_B(in_B), .mode(mode), .A(A), .B(B),
        .array_product(array_product), .array_done(array_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
        .out_error(out_error), .busy(busy), .job_count(job_count)
    );

    meissa_controller #(.DATA_WIDTH(8), .MATRIX_SIZE(4), .STAGE_CYCLES(3), .TIMEOUT(15)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_A(in_A), .in_B(in_B), .mode(mode3), .A(A3), .B(B3),
        .array_product(array_product), .array_done(array_done3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_product(out_product3),
        .out_error(out_error3), .busy(busy3), .job_count(job_count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        vec_cnt++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || mode !== 3'b000) begin
            err_cnt++;
            $display("FAIL reset_ctrl got ready=%b busy=%b mode=%b want 1 0 000", in_ready, busy, mode);
        end
        vec_cnt++;
        if (A !== 32'h0 || B !== 32'h0 || out_product !== 64'h0) begin
            err_cnt++;
            $display("FAIL reset_data got A=%h B=%h prod=%h want zeros", A, B, out_product);
        end
        vec_cnt++;
        if (out_valid !== 1'b0 || out_error !== 1'b0 || job_count !== 8'd0) begin
            err_cnt++;
            $display("FAIL reset_out got valid=%b err=%b jobs=%0d want 0 0 0", out_valid, out_error, job_count);
        end
    endtask

    task automatic test_basic;
        logic [2:0] exp_modes [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
        in_A = 32'h04030201;
        in_B = 32'h08070605;
        in_valid = 1'b1;
        vec_cnt++;
        if (in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL basic_ready got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        vec_cnt++;
        if (A !== 32'h04030201 || B !== 32'h08070605 || busy !== 1'b1 || in_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL basic_capture got A=%h B=%h busy=%b ready=%b", A, B, busy, in_ready);
        end
        for (int s = 0; s < 5; s++) begin
            vec_cnt++;
            if (mode !== exp_modes[s]) begin
                err_cnt++;
                $display("FAIL basic_mode step=%0d got %b want %b", s, mode, exp_modes[s]);
            end
            if (s == 4) begin
                array_product = P1;
                array_done = 1'b1;
            end
            tick();
        end
        array_done = 1'b0;
        vec_cnt++;
        if (out_valid !== 1'b1 || out_product !== P1 || out_error !== 1'b0 || mode !== 3'b000) begin
            err_cnt++;
            $display("FAIL basic_result got v=%b p=%h e=%b m=%b want 1 %h 0 000", out_valid, out_product, out_error, mode, P1);
        end
    endtask

    task automatic test_hold;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            vec_cnt++;
            if (out_valid !== 1'b1 || out_product !== P1 || in_ready !== 1'b0 || job_count !== 8'd0) begin
                err_cnt++;
                $display("FAIL hold cyc=%0d got v=%b p=%h rdy=%b jobs=%0d", i, out_valid, out_product, in_ready, job_count);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vec_cnt++;
        if (job_count !== 8'd1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL hold_handshake got jobs=%0d v=%b rdy=%b want 1 0 1", job_count, out_valid, in_ready);
        end
    endtask

    task automatic test_timeout;
        int n;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        array_done = 1'b1;
        repeat (4) tick();
        array_done = 1'b0;
        n = 0;
        while (mode === 3'b101 && n < 40) begin
            n++;
            tick();
        end
        vec_cnt++;
        if (n != 15) begin
            err_cnt++;
            $display("FAIL timeout_cycles got %0d want 15", n);
        end
        vec_cnt++;
        if (out_valid !== 1'b1 || out_error !== 1'b1 || out_product !== 64'h0) begin
            err_cnt++;
            $display("FAIL timeout_result got v=%b e=%b p=%h want 1 1 0", out_valid, out_error, out_product);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vec_cnt++;
        if (job_count !== 8'd2) begin
            err_cnt++;
            $display("FAIL timeout_jobs got %0d want 2", job_count);
        end
    endtask

    task automatic test_ignore_inputs;
        in_A = 32'hA1A2A3A4;
        in_B = 32'hB1B2B3B4;
        in_valid = 1'b1;
        tick();
        for (int s = 0; s < 4; s++) begin
            in_A = in_A + 32'h11111111;
            in_B = in_B - 32'h01010101;
            vec_cnt++;
            if (A !== 32'hA1A2A3A4 || B !== 32'hB1B2B3B4) begin
                err_cnt++;
                $display("FAIL ignore_hold step=%0d got A=%h B=%h", s, A, B);
            end
            tick();
        end
        array_product = P2;
        array_done = 1'b1;
        tick();
        array_done = 1'b0;
        in_A = 32'hC1C2C3C4;
        in_B = 32'hD1D2D3D4;
        vec_cnt++;
        if (A !== 32'hA1A2A3A4 || in_ready !== 1'b0 || out_product !== P2) begin
            err_cnt++;
            $display("FAIL ignore_result got A=%h rdy=%b p=%h", A, in_ready, out_product);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vec_cnt++;
        if (in_ready !== 1'b1 || A !== 32'hA1A2A3A4 || job_count !== 8'd3) begin
            err_cnt++;
            $display("FAIL ignore_idle got rdy=%b A=%h jobs=%0d want 1 a1a2a3a4 3", in_ready, A, job_count);
        end
        tick();
        in_valid = 1'b0;
        vec_cnt++;
        if (A !== 32'hC1C2C3C4 || B !== 32'hD1D2D3D4 || mode !== 3'b001) begin
            err_cnt++;
            $display("FAIL ignore_second got A=%h B=%h m=%b", A, B, mode);
        end
    endtask

    task automatic test_reset_midjob;
        int pulses;
        tick();
        tick();
        vec_cnt++;
        if (mode !== 3'b011) begin
            err_cnt++;
            $display("FAIL midrst_pre got mode=%b want 011", mode);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vec_cnt++;
        if (mode !== 3'b000 || A !== 32'h0 || B !== 32'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL midrst_ctrl got m=%b A=%h B=%h busy=%b rdy=%b", mode, A, B, busy, in_ready);
        end
        vec_cnt++;
        if (job_count !== 8'd0 || out_valid !== 1'b0 || out_error !== 1'b0 || out_product !== 64'h0) begin
            err_cnt++;
            $display("FAIL midrst_out got jobs=%0d v=%b e=%b p=%h", job_count, out_valid, out_error, out_product);
        end
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b0 || mode !== 3'b000) pulses++;
            tick();
        end
        vec_cnt++;
        if (pulses != 0) begin
            err_cnt++;
            $display("FAIL midrst_quiet got %0d active cycles want 0", pulses);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        int dwell [8];
        for (int j = 0; j < 256; j++) begin
            in_valid3 = 1'b1;
            tick();
            in_valid3 = 1'b0;
            for (int m = 0; m < 8; m++) dwell[m] = 0;
            n = 0;
            while (out_valid3 !== 1'b1 && n < 40) begin
                array_done3 = (mode3 === 3'b101);
                dwell[mode3]++;
                n++;
                tick();
            end
            array_done3 = 1'b0;
            if (j == 0) begin
                vec_cnt++;
                if (dwell[1] != 3 || dwell[2] != 3 || dwell[3] != 3 || dwell[4] != 3 || dwell[5] != 1) begin
                    err_cnt++;
                    $display("FAIL b2b_dwell got %0d %0d %0d %0d %0d want 3 3 3 3 1",
                             dwell[1], dwell[2], dwell[3], dwell[4], dwell[5]);
                end
                vec_cnt++;
                if (n != 13) begin
                    err_cnt++;
                    $display("FAIL b2b_latency got %0d cycles want 13", n);
                end
            end
            if (n >= 40) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL b2b_stall job=%0d no out_valid within 40 cycles", j);
                break;
            end
            out_ready3 = 1'b1;
            tick();
            out_ready3 = 1'b0;
            if (j == 0 || j == 254 || j == 255) begin
                vec_cnt++;
                if (job_count3 !== 8'((j + 1) % 256)) begin
                    err_cnt++;
                    $display("FAIL b2b_jobs job=%0d got %0d want %0d", j, job_count3, (j + 1) % 256);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        array_done = 1'b0;
        in_valid3 = 1'b0;
        out_ready3 = 1'b0;
        array_done3 = 1'b0;
        in_A = '0;
        in_B = '0;
        array_product = '0;
        test_reset();
        test_basic();
        test_hold();
        test_timeout();
        test_ignore_inputs();
        test_reset_midjob();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
